// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, widths and result model for the ALU command driver
package alu_pkg;

   localparam int DATA_W = 4;
   localparam int RES_W  = 5;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_INV = 2'b10,
      OP_ROR = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      INIT  = 2'b00,
      RUN   = 2'b01,
      FLUSH = 2'b10
   } drv_state_e;

   // Operands are sign-extended to the result width before arithmetic.
   function automatic logic [RES_W-1:0] alu_expected(input logic [1:0] op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
      logic [RES_W-1:0] sa;
      logic [RES_W-1:0] sb;
      logic [RES_W-1:0] res;
      sa = {a[DATA_W-1], a};
      sb = {b[DATA_W-1], b};
      case (alu_op_e'(op))
         OP_ADD:  res = sa + sb;
         OP_SUB:  res = sa - sb;
         OP_INV:  res = ~sa;
         default: res = {{(RES_W-1){1'b0}}, |b};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - synchronous response FIFO with occupancy count and flush clear
module alu_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Explicit wrap so non-power-of-two depths stay correct.
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - command/response front end for the 4-bit ALU
// Optional result checking: ALU_CMD_CHECK_EN
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int ALU_LAT   = 1,
   parameter int RSP_DEPTH = 4,
   parameter int TAG_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_opcode,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [TAG_W-1:0]  cmd_tag,
   output logic              alu_reset,
   output logic [1:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [RES_W-1:0]  alu_c,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_result,
   output logic [TAG_W-1:0]  rsp_tag,
`ifdef ALU_CMD_CHECK_EN
   output logic              rsp_mismatch,
   output logic [15:0]       err_count,
`endif
   output logic              busy
);

   localparam int CW = $clog2(RSP_DEPTH+1);
`ifdef ALU_CMD_CHECK_EN
   localparam int FW = RES_W + TAG_W + 1;
`else
   localparam int FW = RES_W + TAG_W;
`endif

   drv_state_e       state;
   logic             init_cnt;
   logic [ALU_LAT:0] pv;
   logic [TAG_W-1:0] ptag [ALU_LAT+1];
   logic             accept;
   logic             clear;
   logic             push;
   logic             pop;
   logic [FW-1:0]    push_data;
   logic [FW-1:0]    pop_data;
   logic [CW-1:0]    fifo_cnt;
   int unsigned      inflight;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= INIT;
         init_cnt <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               init_cnt <= 1'b1;
               if (init_cnt) state <= RUN;
            end
            RUN:     if (flush) state <= FLUSH;
            default: state <= RUN;
         endcase
      end
   end

   assign alu_reset = (state != RUN);
   assign clear     = (state == RUN) && flush;

   always_comb begin
      inflight = 0;
      for (int i = 0; i <= ALU_LAT; i++) inflight = inflight + 32'(pv[i]);
   end

   // Credit counts in-flight plus queued; a same-cycle pop does not free a slot.
   assign cmd_ready = (state == RUN) && !flush &&
                      ((inflight + 32'(fifo_cnt)) < 32'(RSP_DEPTH));
   assign accept    = cmd_valid && cmd_ready;
   assign push      = pv[ALU_LAT] && !clear;
   assign rsp_valid = (fifo_cnt != '0) && (state == RUN);
   assign pop       = rsp_valid && rsp_ready;
   assign busy      = (inflight != 0) || (fifo_cnt != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pv         <= '0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
      end else begin
         pv <= clear ? '0 : {pv[ALU_LAT-1:0], accept};
         if (accept) begin
            alu_opcode <= cmd_opcode;
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      ptag[0] <= cmd_tag;
      for (int i = 1; i <= ALU_LAT; i++) ptag[i] <= ptag[i-1];
   end

`ifdef ALU_CMD_CHECK_EN
   logic [RES_W-1:0] pexp [ALU_LAT+1];
   logic             mismatch;

   always_ff @(posedge clk) begin
      pexp[0] <= alu_expected(cmd_opcode, cmd_a, cmd_b);
      for (int i = 1; i <= ALU_LAT; i++) pexp[i] <= pexp[i-1];
   end

   assign mismatch  = (alu_c != pexp[ALU_LAT]);
   assign push_data = {mismatch, ptag[ALU_LAT], alu_c};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                     err_count <= '0;
      else if (push && mismatch && err_count != '1)   err_count <= err_count + 16'd1;
   end

   assign rsp_mismatch = pop_data[FW-1];
`else
   assign push_data = {ptag[ALU_LAT], alu_c};
`endif

   alu_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .W     (FW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clr       (clear),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .count     (fifo_cnt)
   );

   assign rsp_result = pop_data[RES_W-1:0];
   assign rsp_tag    = pop_data[RES_W +: TAG_W];

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver with a behavioural ALU
module tb_alu_cmd_driver;

   localparam int RSP_DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_opcode;
   logic [3:0]  cmd_a;
   logic [3:0]  cmd_b;
   logic [3:0]  cmd_tag;
   logic        alu_reset;
   logic [1:0]  alu_opcode;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [4:0]  alu_c;
   logic [4:0]  alu_c_q;
   logic        force_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [4:0]  rsp_result;
   logic [3:0]  rsp_tag;
   logic        busy;
`ifdef ALU_CMD_CHECK_EN
   logic        rsp_mismatch;
   logic [15:0] err_count;
`endif

   int total = 0;
   int bad   = 0;
   int acc_n = 0;
   int rsp_n = 0;
   int base;
   int idx;
   int drop;
   bit last_acc;
   bit chk_credit = 0;
   bit sb_off     = 0;
   logic [4:0] sb_res [$];
   logic [3:0] sb_tag [$];

   logic [1:0] d_op [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
   logic [3:0] d_a  [4] = '{4'h8, 4'h7, 4'h0, 4'h0};
   logic [3:0] d_b  [4] = '{4'h7, 4'h0, 4'h0, 4'hC};

   alu_cmd_driver #(
      .ALU_LAT   (1),
      .RSP_DEPTH (RSP_DEPTH),
      .TAG_W     (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_tag      (cmd_tag),
      .alu_reset    (alu_reset),
      .alu_opcode   (alu_opcode),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_c        (alu_c),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_tag      (rsp_tag),
`ifdef ALU_CMD_CHECK_EN
      .rsp_mismatch (rsp_mismatch),
      .err_count    (err_count),
`endif
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: registered output, synchronous active-high reset.
   always @(posedge clk) begin
      if (alu_reset) alu_c_q <= 5'd0;
      else           alu_c_q <= alu_pkg::alu_expected(alu_opcode, alu_a, alu_b);
   end
   assign alu_c = force_zero ? 5'd0 : alu_c_q;

   // Reference result from signed integer arithmetic, truncated to 5 bits.
   function automatic logic [4:0] ref_result(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      int sa;
      int sb;
      int r;
      sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
      sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
      case (op)
         2'd0:    r = sa + sb;
         2'd1:    r = sa - sb;
         2'd2:    r = -sa - 1;
         default: r = (b != 4'd0) ? 1 : 0;
      endcase
      return 5'(r);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] t);
      cmd_valid  = v;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_tag    = t;
   endtask

   task automatic drive_rand(input logic v);
      drive(v, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
   endtask

   // One clock: observe handshakes before the rising edge, return 1 after it.
   task automatic step();
      @(negedge clk);
      last_acc = cmd_valid && cmd_ready;
      if (chk_credit) begin
         chk("credit", 32'(cmd_ready), 32'(sb_res.size() < RSP_DEPTH));
         chk("busy_model", 32'(busy), 32'(sb_res.size() != 0));
      end
      if (last_acc) begin
         acc_n++;
         if (!sb_off) begin
            sb_res.push_back(ref_result(cmd_opcode, cmd_a, cmd_b));
            sb_tag.push_back(cmd_tag);
         end
      end
      if (rsp_valid && rsp_ready) begin
         rsp_n++;
         if (!sb_off) begin
            chk("rsp_expected", 32'(sb_res.size() != 0), 32'd1);
            if (sb_res.size() != 0) begin
               chk("rsp_result", 32'(rsp_result), 32'(sb_res.pop_front()));
               chk("rsp_tag", 32'(rsp_tag), 32'(sb_tag.pop_front()));
`ifdef ALU_CMD_CHECK_EN
               chk("rsp_mismatch_clean", 32'(rsp_mismatch), 32'd0);
`endif
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      rsp_ready = 1'b0;
      force_zero = 1'b0;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_reset", 32'(alu_reset), 32'd1);
      chk("rst_alu_inputs", 32'({alu_opcode, alu_a, alu_b}), 32'd0);

      // Release and idle through the ALU reset window.
      reset = 1'b1;
      chk("init1_alu_reset", 32'(alu_reset), 32'd1);
      chk("init1_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
      chk("init2_alu_reset", 32'(alu_reset), 32'd1);
      chk("init2_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
      chk("run_alu_reset", 32'(alu_reset), 32'd0);
      chk("run_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("run_rsp_valid", 32'(rsp_valid), 32'd0);

      // Single add 7+7, tag 3.
      drive(1, 2'd0, 4'd7, 4'd7, 4'd3);
      step();
      chk("add_accepted", 32'(last_acc), 32'd1);
      drive(0, 0, 0, 0, 0);
      chk("add_lat1", 32'(rsp_valid), 32'd0);
      step();
      chk("add_lat2", 32'(rsp_valid), 32'd0);
      step();
      chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("add_rsp_result", 32'(rsp_result), 32'd14);
      chk("add_rsp_tag", 32'(rsp_tag), 32'd3);
      rsp_ready = 1'b1;
      step();
      chk("add_busy_after", 32'(busy), 32'd0);

      // Back-to-back sub/inv/ror/ror with the response side always ready.
      base = rsp_n;
      drop = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, d_op[i], d_a[i], d_b[i], 4'(i + 4));
         step();
         if (!last_acc) drop++;
      end
      drive(0, 0, 0, 0, 0);
      chk("b2b_rsp_after_issue", 32'(rsp_n - base), 32'd1);
      repeat (3) step();
      chk("b2b_rsp_total", 32'(rsp_n - base), 32'd4);
      chk("b2b_ready_drops", 32'(drop), 32'd0);
      chk("b2b_known_sub", 32'(ref_result(2'd1, 4'h8, 4'h7)), 32'h11);
      chk("b2b_known_inv", 32'(ref_result(2'd2, 4'h7, 4'h0)), 32'h18);

      // Backpressure: only RSP_DEPTH commands fit.
      rsp_ready = 1'b0;
      idx = 0;
      base = rsp_n;
      repeat (8) begin
         if (idx < 6) drive_rand(1); else drive(0, 0, 0, 0, 0);
         step();
         if (last_acc) idx++;
      end
      chk("bp_accepted", 32'(idx), 32'd4);
      chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      rsp_ready = 1'b1;
      #1;
      chk("bp_no_same_cycle_credit", 32'(cmd_ready), 32'd0);
      for (int n = 0; n < 40 && !(idx == 6 && sb_res.size() == 0 && !busy); n++) begin
         if (idx < 6) drive_rand(1); else drive(0, 0, 0, 0, 0);
         step();
         if (last_acc) idx++;
      end
      drive(0, 0, 0, 0, 0);
      chk("bp_all_accepted", 32'(idx), 32'd6);
      chk("bp_all_returned", 32'(rsp_n - base), 32'd6);

      // Flush with two in flight and one queued.
      rsp_ready = 1'b0;
      base = acc_n;
      for (int i = 0; i < 3; i++) begin
         drive_rand(1);
         step();
      end
      chk("fl_accepted", 32'(acc_n - base), 32'd3);
      drive_rand(1);
      flush = 1'b1;
      #1;
      chk("fl_blocks_cmd", 32'(cmd_ready), 32'd0);
      chk("fl_busy_before", 32'(busy), 32'd1);
      step();
      flush = 1'b0;
      drive(0, 0, 0, 0, 0);
      sb_res.delete();
      sb_tag.delete();
      chk("fl_alu_reset", 32'(alu_reset), 32'd1);
      chk("fl_busy", 32'(busy), 32'd0);
      chk("fl_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("fl_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
      chk("fl_alu_reset_end", 32'(alu_reset), 32'd0);
      chk("fl_cmd_ready_back", 32'(cmd_ready), 32'd1);
      rsp_ready = 1'b1;
      base = rsp_n;
      repeat (4) step();
      chk("fl_no_rsp", 32'(rsp_n - base), 32'd0);

      // Randomized traffic against the queue model, including credit and busy.
      chk_credit = 1;
      repeat (400) begin
         drive_rand(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
         rsp_ready = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
         step();
      end
      chk_credit = 0;
      drive(0, 0, 0, 0, 0);
      rsp_ready = 1'b1;
      for (int n = 0; n < 50 && (sb_res.size() != 0 || busy); n++) step();
      chk("rand_drained", 32'(sb_res.size()), 32'd0);
      chk("rand_busy", 32'(busy), 32'd0);

      // Reset while work is outstanding.
      rsp_ready = 1'b0;
      repeat (5) begin
         drive_rand(1);
         step();
      end
      drive(0, 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      sb_res.delete();
      sb_tag.delete();
      chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("mr_alu_reset", 32'(alu_reset), 32'd1);
      repeat (2) step();
      reset = 1'b1;
      repeat (2) step();
      chk("mr_ready_again", 32'(cmd_ready), 32'd1);
      rsp_ready = 1'b1;
      base = rsp_n;
      repeat (4) step();
      chk("mr_no_stale_rsp", 32'(rsp_n - base), 32'd0);

`ifdef ALU_CMD_CHECK_EN
      chk("chk_err_zero", 32'(err_count), 32'd0);
      rsp_ready = 1'b0;
      force_zero = 1'b1;
      sb_off = 1;
      drive(1, 2'd0, 4'd7, 4'd0, 4'd9);
      step();
      drive(0, 0, 0, 0, 0);
      repeat (2) step();
      chk("chk_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("chk_mismatch", 32'(rsp_mismatch), 32'd1);
      chk("chk_result", 32'(rsp_result), 32'd0);
      chk("chk_err_count", 32'(err_count), 32'd1);
      force_zero = 1'b0;
      rsp_ready = 1'b1;
      step();
      sb_off = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator-side front end for the 4-bit ALU (ALU_4_bit), which has a registered output and a synchronous active-high reset.
- Accepts packed ALU commands on a valid/ready stream and drives Opcode/A/B into the ALU.
- Tracks the in-flight operations, captures each result C and returns it with its tag on a valid/ready response stream.
- A credit-limited response FIFO absorbs response backpressure.
- Sits between a command source (sequencer or CPU port) and the ALU.

Parameters:
- ALU_LAT, 1, ALU input-to-output latency in cycles; must be ≥1.
- RSP_DEPTH, 4, response FIFO depth; must be ≥ ALU_LAT+3 for one command per cycle.
- TAG_W, 4, command/response tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  soft flush, one-cycle pulse.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_opcode  in  2  00 add, 01 sub, 10 invert A, 11 reduction-OR B.
- cmd_a  in  4  signed operand A.
- cmd_b  in  4  signed operand B.
- cmd_tag  in  TAG_W  opaque tag, returned with the response.
- alu_reset  out  1  synchronous active-high reset to the ALU.
- alu_opcode  out  2  to ALU Opcode.
- alu_a  out  4  to ALU A.
- alu_b  out  4  to ALU B.
- alu_c  in  5  ALU result C.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_result  out  5  captured alu_c.
- rsp_tag  out  TAG_W  tag of the matching command.
- busy  out  1  high while anything is in flight or queued.

Behaviour:
- Reset (reset=0, async): state=INIT. alu_reset=1. cmd_ready=0, rsp_valid=0, busy=0. alu_opcode/alu_a/alu_b=0. Pipeline valid bits, FIFO pointers and count are cleared.
- FSM INIT: hold alu_reset=1 for 2 cycles after reset deasserts, then go to RUN.
- FSM RUN: normal operation, alu_reset=0.
- FSM FLUSH: entered on flush=1 in RUN. In the entry cycle, clear all pipeline valid bits and the FIFO, and set alu_reset=1 for exactly 1 cycle. cmd_ready=0 and rsp_valid=0 during FLUSH. Next cycle returns to RUN.
- flush in INIT is ignored.
- Issue: on accept at edge N, register alu_opcode/alu_a/alu_b and push {valid=1, tag} into stage 0 of an ALU_LAT+1 deep tracking pipe. With no accept, the alu_* outputs hold their value and stage 0 gets valid=0.
- Capture: when the pipe's last stage is valid, write alu_c into the FIFO at edge N+ALU_LAT+1. Earliest rsp_valid is therefore ALU_LAT+1 cycles after accept (2 by default).
- Ordering: responses are returned strictly in command order.
- Credit: cmd_ready = (state==RUN) && (inflight_cnt + fifo_cnt < RSP_DEPTH).
  - A pop in the same cycle does not return credit, so the FIFO can never overflow.
- FIFO:
  - rsp_valid = (fifo_cnt != 0) && state==RUN.
  - Pointers are log2(RSP_DEPTH) bits and wrap modulo RSP_DEPTH.
  - Simultaneous push and pop leaves fifo_cnt unchanged.
  - Pop from empty and push when full cannot occur, by construction.
- Result values expected from the ALU, all 5-bit:
  - add = sext(A)+sext(B).
  - sub = sext(A)−sext(B).
  - invert = ~sext(A).
  - reduction-OR = {4'b0, |B}.
- busy = inflight_cnt!=0 || fifo_cnt!=0.
- Reset mid-operation: all in-flight and queued responses are discarded with no partial output.
- Flush coinciding with a command handshake: the command is not accepted, because cmd_ready=0 is forced combinationally when flush=1.

Optional Feature:
- Macro: ALU_CMD_CHECK_EN.
- When defined:
  - An internal reference model computes the expected result at issue and carries it down the pipe.
  - Extra outputs: rsp_mismatch (1 bit, alongside rsp_result) and err_count (16 bits, saturating, cleared by reset only).
  - err_count increments at capture when alu_c differs from the expected value.
- When undefined: none of these ports or logic exist.

Decomposition:
- Package alu_pkg holds:
  - opcode enum (OP_ADD, OP_SUB, OP_INV, OP_ROR);
  - driver state enum (INIT, RUN, FLUSH);
  - constants DATA_W=4 and RES_W=5;
  - function alu_expected(op, a, b), shared with the bench.
- One sub-module: alu_rsp_fifo (parameterised sync FIFO with count output).

Test Plan:
- Reset then 3 idle cycles → alu_reset high for 2 cycles after release, cmd_ready rises on the 3rd cycle, rsp_valid=0.
- Single add, A=7, B=7, tag=3 → rsp_valid 2 cycles after accept, rsp_result=14 (01110), rsp_tag=3.
- Back-to-back commands with rsp_ready=1: sub(−8,7)→−15, inv(7)→11000, ror(B=0)→0, ror(B=1100)→1 → one response per cycle, in order, cmd_ready never drops.
- rsp_ready=0 while issuing 6 commands → exactly 4 accepted, then cmd_ready=0. Raise rsp_ready → 4 responses drain, then the remaining 2 are accepted.
- flush pulse with 2 commands in flight and 1 queued → alu_reset=1 for 1 cycle, no responses emitted, busy=0 the next cycle.
- With ALU_CMD_CHECK_EN, force alu_c to 0 on an add of 7+0 → rsp_mismatch=1 with rsp_result=0, err_count=1.
